// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: attract, serve, rally, point freeze and game over.
// It keeps the match score and tells the ball/paddle datapath when to move.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic       clk_pix,
  input  logic       rst,
  input  logic       animate,
  input  logic       sig_ctrl,
  input  logic       lft_col,
  input  logic       rgt_col,
  output logic       reset_pos,
  output logic       run,
  output logic       p1_human,
  output logic       serve_dx,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_over,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [3:0] WIN_N   = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_N = 8'(SERVE_FRAMES);
  localparam logic [7:0] POINT_N = 8'(POINT_FRAMES);

  state_t     state, nxt;
  logic [7:0] cnt, cnt_inc;
  logic       won;

  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign won     = (score_p1 >= WIN_N) || (score_p2 >= WIN_N);

  // Frame timeouts fire on the animate pulse that brings the count to its limit.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (sig_ctrl) nxt = SERVE;
      SERVE: if (sig_ctrl || (animate && cnt_inc >= SERVE_N)) nxt = PLAY;
      PLAY:  if (lft_col || rgt_col) nxt = POINT;
      POINT: if (animate && cnt_inc >= POINT_N) nxt = won ? OVER : SERVE;
      OVER:  if (sig_ctrl) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      score_p1  <= 4'd0;
      score_p2  <= 4'd0;
      serve_dx  <= 1'b0;
      reset_pos <= 1'b1;
      run       <= 1'b0;
      p1_human  <= 1'b0;
      game_over <= 1'b0;
      state_dbg <= IDLE;
    end else begin
      state <= nxt;
      if (nxt != state) cnt <= 8'd0;
      else if (animate) cnt <= cnt_inc;

      if (state == IDLE && sig_ctrl) begin
        score_p1 <= 4'd0;
        score_p2 <= 4'd0;
        serve_dx <= 1'b0;
      end

      // Simultaneous edge hits are a replay: nobody scores, serve side kept.
      if (state == PLAY) begin
        if (rgt_col && !lft_col) begin
          if (score_p1 != 4'hF) score_p1 <= score_p1 + 4'd1;
          serve_dx <= 1'b1;
        end else if (lft_col && !rgt_col) begin
          if (score_p2 != 4'hF) score_p2 <= score_p2 + 4'd1;
          serve_dx <= 1'b0;
        end
      end

      // Outputs are registered copies of the decode of the state being entered.
      reset_pos <= (nxt == IDLE) || (nxt == SERVE);
      run       <= (nxt == PLAY);
      p1_human  <= (nxt == SERVE) || (nxt == PLAY) || (nxt == POINT);
      game_over <= (nxt == OVER);
      state_dbg <= nxt;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scenario bench for pong_game_ctrl: each driven cycle queues its expected
// outputs, which are popped and compared once the clock edge has happened.
module tb_pong_game_ctrl;

  logic       clk_pix = 1'b0;
  logic       rst = 1'b0, animate = 1'b0, sig_ctrl = 1'b0, lft_col = 1'b0, rgt_col = 1'b0;
  logic       reset_pos, run, p1_human, serve_dx, game_over;
  logic [3:0] score_p1, score_p2;
  logic [2:0] state_dbg;

  pong_game_ctrl dut (
    .clk_pix(clk_pix), .rst(rst), .animate(animate), .sig_ctrl(sig_ctrl),
    .lft_col(lft_col), .rgt_col(rgt_col), .reset_pos(reset_pos), .run(run),
    .p1_human(p1_human), .serve_dx(serve_dx), .score_p1(score_p1),
    .score_p2(score_p2), .game_over(game_over), .state_dbg(state_dbg)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct {
    string tag;
    int    st, s1, s2, dx;
  } exp_t;

  exp_t sbq[$];
  int   total = 0, bad = 0;
  int   e_s1 = 0, e_s2 = 0, e_dx = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    e = sbq.pop_front();
    chk({e.tag, ":state"},     int'(state_dbg), e.st);
    chk({e.tag, ":score_p1"},  int'(score_p1),  e.s1);
    chk({e.tag, ":score_p2"},  int'(score_p2),  e.s2);
    chk({e.tag, ":serve_dx"},  int'(serve_dx),  e.dx);
    chk({e.tag, ":reset_pos"}, int'(reset_pos), (e.st <= 1) ? 1 : 0);
    chk({e.tag, ":run"},       int'(run),       (e.st == 2) ? 1 : 0);
    chk({e.tag, ":p1_human"},  int'(p1_human),  (e.st >= 1 && e.st <= 3) ? 1 : 0);
    chk({e.tag, ":game_over"}, int'(game_over), (e.st == 4) ? 1 : 0);
  endtask

  // One clock of stimulus; est is the state expected after the edge.
  task automatic step(input string tag, input bit a, input bit s, input bit l,
                      input bit r, input bit rs, input int est);
    exp_t e;
    e.tag = tag; e.st = est; e.s1 = e_s1; e.s2 = e_s2; e.dx = e_dx;
    sbq.push_back(e);
    animate = a; sig_ctrl = s; lft_col = l; rgt_col = r; rst = rs;
    @(posedge clk_pix);
    #1;
    animate = 1'b0; sig_ctrl = 1'b0; lft_col = 1'b0; rgt_col = 1'b0; rst = 1'b0;
    sb_check();
  endtask

  // n animate pulses, one idle cycle after each; state flips on the last.
  task automatic frames(input string tag, input int n, input int during, input int fin);
    for (int i = 0; i < n; i++) begin
      step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (i == n - 1) ? fin : during);
      step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (i == n - 1) ? fin : during);
    end
  endtask

  initial begin
    #2;
    // Reset wins over every other input.
    step("rst",        1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    step("rst_hold",   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    step("idle_noise", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    step("idle_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    frames("serve60", 60, 1, 2);
    step("play_ctrl",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    step("play_anim",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2);

    e_s1 = 1; e_dx = 1;
    step("p1_point",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    step("point_col",  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3);
    step("point_ctrl", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    frames("point30", 30, 3, 1);

    frames("serve5", 5, 1, 1);
    step("serve_ctrl", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    step("both_col",   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3);
    frames("replay30", 30, 3, 1);

    // P2 wins nine rallies; the ninth point leads to game over.
    for (int k = 1; k <= 9; k++) begin
      step("p2_serve", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
      e_s2 = k; e_dx = 0;
      step("p2_point", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3);
      frames("p2_freeze", 30, 3, (k == 9) ? 4 : 1);
    end
    step("over_noise", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4);
    step("over_exit",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step("idle_hold",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    e_s1 = 0; e_s2 = 0; e_dx = 0;
    step("new_match",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);

    // Build score_p1 to 5, then reset in the middle of the point freeze.
    for (int k = 1; k <= 5; k++) begin
      step("p1_serve", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
      e_s1 = k; e_dx = 1;
      step("p1_score", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
      if (k < 5) frames("p1_freeze", 30, 3, 1);
    end
    frames("pt_partial", 10, 3, 3);
    e_s1 = 0; e_s2 = 0; e_dx = 0;
    step("rst_point",  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0);

    step("re_serve",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    step("re_play",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    step("rst_play",   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 9: points needed to win a match (1..15).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60: frames in SERVE before auto-serve (1..255).
REQ-003 SHALL have parameter POINT_FRAMES, default 30: frames the ball stays frozen after a point (1..255).
REQ-004 SHALL have port clk_pix, input, 1 bit: pixel clock; the only clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port animate, input, 1 bit: one-cycle pulse once per frame, at start of vertical blanking.
REQ-007 SHALL have port sig_ctrl, input, 1 bit: one-cycle debounced control-button press pulse.
REQ-008 SHALL have port lft_col, input, 1 bit: ball reached left screen edge; level, from the ball datapath.
REQ-009 SHALL have port rgt_col, input, 1 bit: ball reached right screen edge; level.
REQ-010 SHALL have port reset_pos, output, 1 bit: datapath reloads ball and paddle start positions.
REQ-011 SHALL have port run, output, 1 bit: datapath may animate ball and paddles on animate.
REQ-012 SHALL have port p1_human, output, 1 bit: paddle 1 follows the buttons; 0 means AI.
REQ-013 SHALL have port serve_dx, output, 1 bit: initial ball direction, 0 = right (toward P2), 1 = left (toward P1).
REQ-014 SHALL have ports score_p1 and score_p2, output, 4 bits each: match scores.
REQ-015 SHALL have port game_over, output, 1 bit: match finished.
REQ-016 SHALL have port state_dbg, output, 3 bits: current state encoding (IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4).

Function
REQ-017 SHALL be a Moore FSM; reset_pos, run, p1_human, game_over and state_dbg SHALL decode from the registered state only.
REQ-018 IDLE: reset_pos=1, run=0, p1_human=0, attract mode; sig_ctrl -> SERVE, and on that edge scores clear to 0 and serve_dx clears to 0.
REQ-019 SERVE: reset_pos=1, run=0, p1_human=1; frame counter clears on entry and increments on each animate.
REQ-020 SERVE -> PLAY on the cycle after either sig_ctrl=1 or the animate pulse that makes the counter equal SERVE_FRAMES, whichever comes first.
REQ-021 PLAY: reset_pos=0, run=1, p1_human=1; sig_ctrl ignored.
REQ-022 PLAY, rgt_col=1 and lft_col=0: score_p1 increments; serve_dx <= 1; go to POINT.
REQ-023 PLAY, lft_col=1 and rgt_col=0: score_p2 increments; serve_dx <= 0; go to POINT.
REQ-024 PLAY, lft_col=1 and rgt_col=1 in the same cycle: no score change, serve_dx unchanged, go to POINT (replay).
REQ-025 Score and serve_dx updates SHALL be registered on the PLAY->POINT transition edge and visible one cycle later, together with the new state.
REQ-026 Scores SHALL saturate at 15 and never wrap.
REQ-027 POINT: reset_pos=0, run=0 (ball frozen in place), p1_human=1; counter clears on entry and counts animate pulses; sig_ctrl ignored.
REQ-028 When the POINT counter reaches POINT_FRAMES: if score_p1 >= WIN_SCORE or score_p2 >= WIN_SCORE, go to OVER; otherwise go to SERVE.
REQ-029 OVER: game_over=1, reset_pos=0, run=0, p1_human=0; scores held; sig_ctrl -> IDLE.
REQ-030 game_over SHALL be 0 in every state except OVER.
REQ-031 lft_col/rgt_col SHALL be ignored outside PLAY.
REQ-032 The frame counter SHALL be 8 bits and SHALL NOT wrap; it holds at its terminal value until the state changes.
REQ-033 Any unused state encoding SHALL go to IDLE on the next cycle.

Reset
REQ-034 rst=1 at a clk_pix edge SHALL force, next cycle: state IDLE, scores 0, serve_dx 0, counter 0, reset_pos=1, run=0, p1_human=0, game_over=0.
REQ-035 rst SHALL take priority over every input in the same cycle, including mid-PLAY and mid-POINT.
REQ-036 Outputs SHALL be defined (not X) from the first clock edge with rst=1.

Verification
REQ-037 Reset, then sig_ctrl, then 60 animate pulses -> state_dbg 1 for 60 frames, then 2; run=1 one cycle after the 60th animate.
REQ-038 In PLAY, rgt_col pulse -> score_p1=1, serve_dx=1, state_dbg=3; after 30 animates -> state_dbg=1.
REQ-039 In PLAY, lft_col and rgt_col high in the same cycle -> scores unchanged, state_dbg=3.
REQ-040 With score_p2=8 and WIN_SCORE=9, lft_col in PLAY, then 30 animates -> score_p2=9, game_over=1, state_dbg=4; sig_ctrl -> state_dbg=0; sig_ctrl -> scores 0.
REQ-041 In SERVE, sig_ctrl after 5 frames -> PLAY next cycle; sig_ctrl in PLAY or POINT -> no state change.
REQ-042 With score_p1=5, rst asserted mid-POINT -> next cycle state_dbg=0, score_p1=0, reset_pos=1.
